alu_result_stage: RTL
=====================

// Module: alu_result_stage
// PURPOSE
//  Registered downstream stage of the 32-bit ALU. Captures result, carryout, overflow, zero plus
//  command and destination tag from the execute path into a small FIFO with valid/ready on both sides.
//  Masks flags that are meaningless for the command and keeps a sticky overflow status bit.
//  Feeds the register-file writeback port.
// PARAMETERS
//  DATA_WIDTH  32  result width
//  TAG_WIDTH   5   destination register tag width
//  DEPTH       2   FIFO entries; power of two, >=2
//  CNT_WIDTH   16  overflow event counter width (ALU_OVF_COUNT_EN only)
// PORTS
//  clk           in   1           clock, rising edge
//  reset         in   1           asynchronous, active-high reset
//  in_valid      in   1           upstream entry valid
//  in_ready      out  1           stage can accept
//  in_result     in   DATA_WIDTH  ALU result
//  in_carryout   in   1           ALU carryout
//  in_overflow   in   1           ALU overflow
//  in_zero       in   1           ALU zero
//  in_command    in   3           ALU command (ADD=0 SUB=1 XOR=2 SLT=3 AND=4 NAND=5 NOR=6 OR=7)
//  in_rd         in   TAG_WIDTH   destination tag
//  out_valid     out  1           head entry valid
//  out_ready     in   1           downstream accepts
//  out_result    out  DATA_WIDTH  head result
//  out_rd        out  TAG_WIDTH   head tag
//  out_flags     out  3           {carry, overflow, zero} of head
//  clear_sticky  in   1           clears sticky_ovf (and counter)
//  sticky_ovf    out  1           set by any accepted entry with masked overflow=1
//  ovf_count     out  CNT_WIDTH   overflow events, saturating (ALU_OVF_COUNT_EN only)
// BEHAVIOUR
//  - push = in_valid & in_ready; pop = out_valid & out_ready; in-order, no drops, no duplicates.
//  - in_ready = (count < DEPTH) from registered count only; no combinational path from out_ready.
//  - out_valid = (count != 0); pushed entry is visible at the output 1 cycle after the push edge.
//  - Full: in_ready=0 and upstream holds. Full with pop: in_ready stays 0 that cycle.
//  - Push and pop in the same cycle (count>0): count unchanged; head advances, tail appends.
//  - Read/write pointers wrap modulo DEPTH; count ranges 0..DEPTH.
//  - Flag mask at push: carry and overflow are forced 0 unless command is ADD or SUB; zero passes through.
//  - out_result/out_rd/out_flags are 0 whenever out_valid=0.
//  - sticky_ovf: set on a push carrying masked overflow=1; cleared by clear_sticky; set wins when both occur.
//  - reset (async, any time, including mid-stream): count=0, pointers=0, out_valid=0, in_ready=1,
//    out_* = 0, sticky_ovf=0, ovf_count=0; all stored entries are discarded.
// CONFIGURATION
//  ALU_OVF_COUNT_EN defined: ovf_count present; +1 per push with masked overflow=1.
//    Saturates at all-ones. clear_sticky zeroes it. Clear and event in the same cycle -> 1.
//  ALU_OVF_COUNT_EN undefined: ovf_count port and counter logic absent; all other behaviour identical.
// STRUCTURE
//  - alu_pkg: command localparams ADD..OR (3'd0..3'd7) and flag bit indices FLAG_CARRY=2, FLAG_OVF=1, FLAG_ZERO=0.
//  - Sub-module alu_skid_fifo: parameterised storage, pointers and count with valid/ready.
//  - Flag mask, sticky bit and counter live in the top module.
// TESTING
//  1. Reset, push result=32'h5, cmd=ADD, rd=3, ovf=0, cry=0 -> next cycle out_valid=1, out_result=5,
//     out_rd=3, out_flags=3'b000.
//  2. out_ready=0, offer A,B,C back-to-back -> A and B accepted, in_ready=0, C held;
//     then out_ready=1 -> A,B,C emerge in order on consecutive cycles.
//  3. cmd=XOR, ovf=1, cry=1 -> out_flags=3'b000, sticky_ovf=0;
//     then cmd=SUB, ovf=1 -> out_flags=3'b010, sticky_ovf=1.
//  4. count=1, push and pop in the same cycle for 10 cycles -> count stays 1, data order preserved,
//     in_ready stays 1.
//  5. clear_sticky in the same cycle as a SUB overflow push -> sticky_ovf=1, ovf_count=1 (macro on).
//     With CNT_WIDTH=4, 20 overflow pushes -> ovf_count=15.
//  6. count=2, assert reset mid-cycle -> out_valid=0 and in_ready=1 immediately, sticky_ovf=0;
//     after release the first push is the next output.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings: command codes, flag bit positions and the flag-mask helper.
package alu_pkg;

  localparam logic [2:0] ADD  = 3'd0;
  localparam logic [2:0] SUB  = 3'd1;
  localparam logic [2:0] XOR  = 3'd2;
  localparam logic [2:0] SLT  = 3'd3;
  localparam logic [2:0] AND  = 3'd4;
  localparam logic [2:0] NAND = 3'd5;
  localparam logic [2:0] NOR  = 3'd6;
  localparam logic [2:0] OR   = 3'd7;

  localparam int unsigned FLAG_CARRY = 2;
  localparam int unsigned FLAG_OVF   = 1;
  localparam int unsigned FLAG_ZERO  = 0;

  // Carry and overflow only carry meaning for the arithmetic commands.
  function automatic logic is_arith(input logic [2:0] cmd);
    return (cmd == ADD) || (cmd == SUB);
  endfunction

endpackage

// File: rtl/alu_skid_fifo.sv
// Small valid/ready FIFO: storage, wrapping pointers and occupancy count.
module alu_skid_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  // Ready depends only on registered count, so out_ready never reaches in_ready.
  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem_q[rptr_q] : '0;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_data;
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: flag masking, result FIFO, sticky overflow status.
// Optional saturating overflow event counter enabled by `define ALU_OVF_COUNT_EN.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 5,
  parameter int unsigned DEPTH      = 2
`ifdef ALU_OVF_COUNT_EN
  ,
  parameter int unsigned CNT_WIDTH  = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  in_carryout,
  input  logic                  in_overflow,
  input  logic                  in_zero,
  input  logic [2:0]            in_command,
  input  logic [TAG_WIDTH-1:0]  in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]  out_rd,
  output logic [2:0]            out_flags,
  input  logic                  clear_sticky,
  output logic                  sticky_ovf
`ifdef ALU_OVF_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  ovf_count
`endif
);

  localparam int unsigned EW = DATA_WIDTH + TAG_WIDTH + 3;

  logic [2:0]    flags_in;
  logic [EW-1:0] fifo_out;
  logic          push_ovf;
  logic          sticky_q, sticky_d;

  always_comb begin
    flags_in             = '0;
    flags_in[FLAG_CARRY] = in_carryout & is_arith(in_command);
    flags_in[FLAG_OVF]   = in_overflow & is_arith(in_command);
    flags_in[FLAG_ZERO]  = in_zero;
  end

  assign push_ovf = in_valid & in_ready & flags_in[FLAG_OVF];

  alu_skid_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_result, in_rd, flags_in}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (fifo_out)
  );

  // FIFO already zeroes its data output while empty.
  assign {out_result, out_rd, out_flags} = fifo_out;

  always_comb begin
    sticky_d = sticky_q;
    if (clear_sticky) sticky_d = 1'b0;
    if (push_ovf)     sticky_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sticky_q <= 1'b0;
    else       sticky_q <= sticky_d;
  end

  assign sticky_ovf = sticky_q;

`ifdef ALU_OVF_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_sticky)                cnt_d = push_ovf ? CNT_WIDTH'(1) : '0;
    else if (push_ovf && cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign ovf_count = cnt_q;
`endif

endmodule
